// File: rtl/r2sdf_stage.sv
// One radix-2 single-path delay-feedback FFT stage: feedback delay line, frame counter and butterfly.
// Define R2SDF_SCALE_EN to run the butterfly one bit wider and halve both results (overflow-free).
module r2sdf_butterfly #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] in0_re,
   input  logic signed [W-1:0] in0_im,
   input  logic signed [W-1:0] in1_re,
   input  logic signed [W-1:0] in1_im,
   output logic signed [W-1:0] out0_re,
   output logic signed [W-1:0] out0_im,
   output logic signed [W-1:0] out1_re,
   output logic signed [W-1:0] out1_im
);
   assign out0_re = in0_re + in1_re;
   assign out0_im = in0_im + in1_im;
   assign out1_re = in0_re - in1_re;
   assign out1_im = in0_im - in1_im;
endmodule

module r2sdf_stage #(
   parameter int WIDTH      = 16,
   parameter int DELAY      = 4,
   parameter int LOG2_DELAY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im,
   output logic                    out_tw,
   output logic [LOG2_DELAY-1:0]   out_idx
);
`ifdef R2SDF_SCALE_EN
   localparam int BW = WIDTH + 1;
`else
   localparam int BW = WIDTH;
`endif

   logic [LOG2_DELAY:0]     cnt_q, cnt_d;
   logic                    primed_q, primed_d;
   logic signed [WIDTH-1:0] dl_re_q [DELAY];
   logic signed [WIDTH-1:0] dl_im_q [DELAY];
   logic signed [WIDTH-1:0] dl_re_d [DELAY];
   logic signed [WIDTH-1:0] dl_im_d [DELAY];
   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
   logic                    out_tw_q, out_tw_d;
   logic [LOG2_DELAY-1:0]   out_idx_q, out_idx_d;

   logic                    phase_b;
   logic signed [WIDTH-1:0] head_re, head_im;
   logic signed [BW-1:0]    bf_a_re, bf_a_im, bf_b_re, bf_b_im;
   logic signed [BW-1:0]    bf0_re, bf0_im, bf1_re, bf1_im;
   logic signed [WIDTH-1:0] s0_re, s0_im, s1_re, s1_im;

   assign phase_b = cnt_q[LOG2_DELAY];
   assign head_re = dl_re_q[DELAY-1];
   assign head_im = dl_im_q[DELAY-1];

`ifdef R2SDF_SCALE_EN
   assign bf_a_re = {head_re[WIDTH-1], head_re};
   assign bf_a_im = {head_im[WIDTH-1], head_im};
   assign bf_b_re = {in_re[WIDTH-1], in_re};
   assign bf_b_im = {in_im[WIDTH-1], in_im};
   // Arithmetic shift floors toward -inf; the wider sum always fits back in WIDTH after halving.
   assign s0_re = WIDTH'(bf0_re >>> 1);
   assign s0_im = WIDTH'(bf0_im >>> 1);
   assign s1_re = WIDTH'(bf1_re >>> 1);
   assign s1_im = WIDTH'(bf1_im >>> 1);
`else
   assign bf_a_re = head_re;
   assign bf_a_im = head_im;
   assign bf_b_re = in_re;
   assign bf_b_im = in_im;
   assign s0_re = bf0_re;
   assign s0_im = bf0_im;
   assign s1_re = bf1_re;
   assign s1_im = bf1_im;
`endif

   r2sdf_butterfly #(.W(BW)) u_bf (
      .in0_re (bf_a_re),
      .in0_im (bf_a_im),
      .in1_re (bf_b_re),
      .in1_im (bf_b_im),
      .out0_re(bf0_re),
      .out0_im(bf0_im),
      .out1_re(bf1_re),
      .out1_im(bf1_im)
   );

   // Phase A stores inputs and replays last frame's differences; phase B emits sums and stores differences.
   always_comb begin
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      dl_re_d     = dl_re_q;
      dl_im_d     = dl_im_q;
      out_valid_d = 1'b0;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_tw_d    = out_tw_q;
      out_idx_d   = out_idx_q;
      if (in_valid) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) primed_d = 1'b1;
         for (int i = DELAY - 1; i > 0; i--) begin
            dl_re_d[i] = dl_re_q[i-1];
            dl_im_d[i] = dl_im_q[i-1];
         end
         dl_re_d[0]  = phase_b ? s1_re : in_re;
         dl_im_d[0]  = phase_b ? s1_im : in_im;
         out_valid_d = phase_b | primed_q;
         out_re_d    = phase_b ? s0_re : head_re;
         out_im_d    = phase_b ? s0_im : head_im;
         out_tw_d    = ~phase_b;
         out_idx_d   = cnt_q[LOG2_DELAY-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         for (int i = 0; i < DELAY; i++) begin
            dl_re_q[i] <= '0;
            dl_im_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_tw_q    <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         dl_re_q     <= dl_re_d;
         dl_im_q     <= dl_im_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_tw_q    <= out_tw_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_tw    = out_tw_q;
   assign out_idx   = out_idx_q;
endmodule
